// File: rtl/div_if.sv
// -----------------------------------------------------------------------------
// div_if -- execute-stage <-> divider handshake bundle.
//
// Signals
//   signed_div_i  1 = signed division, 0 = unsigned
//   opdata1_i     32-bit dividend
//   opdata2_i     32-bit divisor
//   start_i       request; held high until ready_o is seen, then dropped
//   annul_i       flush of the division in progress
//   result_o      {remainder[31:0], quotient[31:0]} (HI, LO)
//   ready_o       result_o valid
//
// Modports
//   master  execute stage (drives operands and handshake)
//   slave   divider (drives result and ready)
// -----------------------------------------------------------------------------
interface div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div -- 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   div_if.slave: operands, start/annul handshake, 64-bit result, ready
//
// Operation
//   FREE   waits for start_i (without annul_i); captures operand magnitudes,
//          signs and the signed flag.
//   BYZERO divisor was zero; result is forced to zero.
//   ON     32 restoring iterations, then sign fix-up.
//   END    presents result_o/ready_o while start_i stays high.
//   A dropped start_i or an annul_i in BYZERO/ON abandons the operation.
// -----------------------------------------------------------------------------
module div (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    // State and datapath registers
    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_sreg;      // {partial remainder, dividend/quotient, lsb}
    logic [31:0] r_divisor;   // |divisor|
    logic        r_sign1;     // dividend sign
    logic        r_sign2;     // divisor sign
    logic        r_signed;
    logic [63:0] r_fix;       // sign-corrected {remainder, quotient}
    logic [63:0] r_result;
    logic        r_ready;

    // Next-state values
    state_t      w_state_nxt;
    logic [5:0]  w_cnt_nxt;
    logic [64:0] w_sreg_nxt;
    logic [31:0] w_divisor_nxt;
    logic        w_sign1_nxt;
    logic        w_sign2_nxt;
    logic        w_signed_nxt;
    logic [63:0] w_fix_nxt;
    logic [63:0] w_result_nxt;
    logic        w_ready_nxt;

    // Combinational helpers
    logic        w_go;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [32:0] w_diff;
    logic [64:0] w_step;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_go = bus.start_i && !bus.annul_i;

    assign w_abs1 = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1)
                                                            : bus.opdata1_i;
    assign w_abs2 = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1)
                                                            : bus.opdata2_i;

    // One restoring step: subtract if the partial remainder allows it.
    assign w_diff = r_sreg[64:32] - {1'b0, r_divisor};
    assign w_step = w_diff[32] ? {r_sreg[63:0], 1'b0}
                               : {w_diff[31:0], r_sreg[31:0], 1'b1};

    assign w_quot = (r_signed && (r_sign1 ^ r_sign2)) ? (~r_sreg[31:0] + 32'd1)
                                                      : r_sreg[31:0];
    assign w_rem  = (r_signed && r_sign1) ? (~r_sreg[64:33] + 32'd1)
                                          : r_sreg[64:33];

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;

    // State and datapath register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FREE;
            r_cnt     <= '0;
            r_sreg    <= '0;
            r_divisor <= '0;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            r_signed  <= 1'b0;
            r_fix     <= '0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sreg    <= w_sreg_nxt;
            r_divisor <= w_divisor_nxt;
            r_sign1   <= w_sign1_nxt;
            r_sign2   <= w_sign2_nxt;
            r_signed  <= w_signed_nxt;
            r_fix     <= w_fix_nxt;
            r_result  <= w_result_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FREE: begin
                if (w_go) begin
                    w_state_nxt = (bus.opdata2_i == 32'd0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                w_state_nxt = w_go ? END : FREE;
            end
            ON: begin
                if (!w_go) begin
                    w_state_nxt = FREE;
                end else if (r_cnt == 6'd32) begin
                    w_state_nxt = END;
                end
            end
            END: begin
                if (!bus.start_i) begin
                    w_state_nxt = FREE;
                end
            end
            default: w_state_nxt = FREE;
        endcase
    end

    // Datapath / output logic.
    // The fixed-up result is parked in r_fix on entry to END and is only
    // published on the following edge, so ready_o lags END entry by one cycle
    // (34 edges for a real division, 2 for a zero divisor).
    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_sreg_nxt    = r_sreg;
        w_divisor_nxt = r_divisor;
        w_sign1_nxt   = r_sign1;
        w_sign2_nxt   = r_sign2;
        w_signed_nxt  = r_signed;
        w_fix_nxt     = r_fix;
        w_result_nxt  = r_result;
        w_ready_nxt   = r_ready;
        case (r_state)
            FREE: begin
                w_result_nxt = '0;
                w_ready_nxt  = 1'b0;
                if (w_go) begin
                    w_cnt_nxt     = '0;
                    w_sreg_nxt    = {32'd0, w_abs1, 1'b0};
                    w_divisor_nxt = w_abs2;
                    w_sign1_nxt   = bus.opdata1_i[31];
                    w_sign2_nxt   = bus.opdata2_i[31];
                    w_signed_nxt  = bus.signed_div_i;
                end
            end
            BYZERO: begin
                w_result_nxt = '0;
                w_ready_nxt  = 1'b0;
                if (w_go) begin
                    w_fix_nxt = '0;
                end
            end
            ON: begin
                w_result_nxt = '0;
                w_ready_nxt  = 1'b0;
                if (w_go) begin
                    if (r_cnt != 6'd32) begin
                        w_sreg_nxt = w_step;
                        w_cnt_nxt  = r_cnt + 6'd1;
                    end else begin
                        w_fix_nxt = {w_rem, w_quot};
                    end
                end
            end
            END: begin
                if (bus.start_i) begin
                    w_result_nxt = r_fix;
                    w_ready_nxt  = 1'b1;
                end else begin
                    w_result_nxt = '0;
                    w_ready_nxt  = 1'b0;
                end
            end
            default: begin
                w_result_nxt = '0;
                w_ready_nxt  = 1'b0;
            end
        endcase
    end

endmodule
